icache_dm: RTL

ICACHE_DM -- requirements
Module: icache_dm

---
 rtl/icache_dm_pkg.sv | 25 ++
 rtl/icache_data_ram.sv | 24 ++
 rtl/icache_dm.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding
// and the address-field width helpers used by every cache file.
package icache_dm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPARE = 2'd1,
      ST_REFILL  = 2'd2,
      ST_FLUSH   = 2'd3
   } state_t;

   function automatic int offset_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int index_w(input int sets);
      return $clog2(sets);
   endfunction

   // Tag is whatever remains above offset, index and the byte lane bits.
   function automatic int tag_w(input int addr_w, input int line_words, input int sets);
      return addr_w - $clog2(line_words) - $clog2(sets) - 2;
   endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data array: one synchronous write port, one asynchronous read
// port. Contents are intentionally not reset.
module icache_data_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with word-serial line refill and a
// flush that is deferred until any in-flight fetch has been delivered.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | ready for a fetch; flush wins over a simultaneous request
// ST_COMPARE | tag check on the held pc; a hit delivers and may chain
// ST_REFILL  | fetching the line word by word from backing memory
// ST_FLUSH   | clearing every valid bit, then back to idle
module icache_dm
   import icache_dm_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 64
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rq,
   input  logic [ADDR_W-1:0] i_pc,
   output logic              o_ready,
   output logic              o_valid,
   output logic [WIDTH-1:0]  o_data,
   input  logic              i_flush,
   output logic              o_mem_rq,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_ack,
   input  logic [WIDTH-1:0]  i_mem_data
);

   localparam int OFFSET_W = offset_w(LINE_WORDS);
   localparam int INDEX_W  = index_w(SETS);
   localparam int TAG_W    = tag_w(ADDR_W, LINE_WORDS, SETS);
   localparam int RAM_AW   = INDEX_W + OFFSET_W;

   state_t              state;
   logic [ADDR_W-3:0]   pc_q;
   logic [OFFSET_W-1:0] cnt;
   logic [SETS-1:0]     valid;
   logic                flush_pend;
   logic [TAG_W-1:0]    tag_mem [SETS];

   logic [OFFSET_W-1:0] pc_off;
   logic [INDEX_W-1:0]  pc_idx;
   logic [TAG_W-1:0]    pc_tag;
   logic                hit;
   logic                fill_we;
   logic                fill_last;
   logic                accept;
   logic [WIDTH-1:0]    rd_data;
   logic                unused_pc_lsb;

   assign unused_pc_lsb = ^i_pc[1:0];

   assign pc_off    = pc_q[OFFSET_W-1:0];
   assign pc_idx    = pc_q[OFFSET_W +: INDEX_W];
   assign pc_tag    = pc_q[ADDR_W-3 -: TAG_W];
   assign hit       = (state == ST_COMPARE) && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
   assign fill_we   = (state == ST_REFILL) && i_mem_ack;
   assign fill_last = (cnt == OFFSET_W'(LINE_WORDS - 1));

   // A pending or arriving flush blocks chaining so it lands before the next fetch.
   always_comb begin
      o_ready = 1'b0;
      case (state)
         ST_IDLE:    o_ready = !i_flush;
         ST_COMPARE: o_ready = hit && !flush_pend && !i_flush;
         default:    o_ready = 1'b0;
      endcase
   end

   assign accept     = o_ready && i_rq;
   assign o_valid    = hit;
   assign o_data     = hit ? rd_data : '0;
   assign o_mem_rq   = (state == ST_REFILL);
   assign o_mem_addr = (state == ST_REFILL) ? {pc_tag, pc_idx, cnt, 2'b00} : '0;

   icache_data_ram #(
      .WIDTH (WIDTH),
      .DEPTH (SETS * LINE_WORDS),
      .AW    (RAM_AW)
   ) u_data_ram (
      .i_clk   (i_clk),
      .i_we    (fill_we),
      .i_waddr ({pc_idx, cnt}),
      .i_wdata (i_mem_data),
      .i_raddr ({pc_idx, pc_off}),
      .o_rdata (rd_data)
   );

   always_ff @(posedge i_clk) begin
      if (fill_we && fill_last) tag_mem[pc_idx] <= pc_tag;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         pc_q       <= '0;
         cnt        <= '0;
         valid      <= '0;
         flush_pend <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_flush) begin
                  state <= ST_FLUSH;
               end else if (i_rq) begin
                  pc_q  <= i_pc[ADDR_W-1:2];
                  state <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               if (hit) begin
                  if (accept) begin
                     pc_q <= i_pc[ADDR_W-1:2];
                  end else if (flush_pend || i_flush) begin
                     flush_pend <= 1'b0;
                     state      <= ST_FLUSH;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  if (i_flush) flush_pend <= 1'b1;
                  cnt   <= '0;
                  state <= ST_REFILL;
               end
            end
            ST_REFILL: begin
               if (i_flush) flush_pend <= 1'b1;
               if (i_mem_ack) begin
                  cnt <= cnt + OFFSET_W'(1);
                  if (fill_last) begin
                     valid[pc_idx] <= 1'b1;
                     state         <= ST_COMPARE;
                  end
               end
            end
            ST_FLUSH: begin
               valid      <= '0;
               flush_pend <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
